uart_tx_param: RTL

Parametrised UART transmitter for the interferometer's serial telemetry path. It serialises one data word per handshake into a standard asynchronous frame: start bit, LSB-first data, optional parity, then one or two stop bits. Each bit is held for a programmable number of clocks, so no external baud strobe is needed. The block replaces the fixed one-clock-per-bit, 8-bit transmitter and adds a busy/ready handshake with input latching.

---
 rtl/uart_tx_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// UART transmitter: start, LSB-first data, optional parity (UART_TX_PARITY_EN), 1 or 2 stop bits.
// Latency: tx falls 1 cycle after accept; tx_done pulses the cycle after the last stop bit.
// Backpressure: tx_ready low while a frame is in flight; tx_start is ignored then (no queueing).
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 tx_start,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  // Index is shared between data bits and stop bits; DATA_BITS >= 5 keeps it wide enough.
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic                 bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Outputs are computed for the next state so they can be registered without extra latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (tx_start) begin
          state_d = S_START;
          shift_d = din;
          idx_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^din) ^ parity_odd;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
            idx_d   = '0;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_DONE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule
